// File: rtl/bnn_conv_engine_if.sv
// Bus bundle between bnn_conv_engine and its run control, shared SRAM and weight memory.
// The img_count/dim_error status signals exist only when BNN_CONV_STATUS_EN is defined.
interface bnn_conv_engine_if #(
   parameter int MAX_DIM = 16,
   parameter int ADDR_W  = 12
);
   logic               dut_run;
   logic               dut_busy;
   logic [ADDR_W-1:0]  dut_sram_read_address;
   logic [MAX_DIM-1:0] sram_dut_read_data;
   logic [ADDR_W-1:0]  dut_sram_write_address;
   logic [MAX_DIM-1:0] dut_sram_write_data;
   logic               dut_sram_write_enable;
   logic [ADDR_W-1:0]  dut_wmem_read_address;
   logic [15:0]        wmem_dut_read_data;
`ifdef BNN_CONV_STATUS_EN
   logic [7:0]         img_count;
   logic [0:0]         dim_error;
`endif

   modport master (
      input  dut_run, sram_dut_read_data, wmem_dut_read_data,
      output dut_busy, dut_sram_read_address, dut_sram_write_address,
             dut_sram_write_data, dut_sram_write_enable, dut_wmem_read_address
`ifdef BNN_CONV_STATUS_EN
      , output img_count, dim_error
`endif
   );

   modport slave (
      output dut_run, sram_dut_read_data, wmem_dut_read_data,
      input  dut_busy, dut_sram_read_address, dut_sram_write_address,
             dut_sram_write_data, dut_sram_write_enable, dut_wmem_read_address
`ifdef BNN_CONV_STATUS_EN
      , input img_count, dim_error
`endif
   );
endinterface

// File: rtl/bnn_conv_engine.sv
// Binary 3x3 XNOR-popcount-threshold convolution over a stream of NxN bit-images.
// Optional status outputs (img_count, dim_error) are enabled by BNN_CONV_STATUS_EN.
module bnn_conv_engine #(
   parameter int MAX_DIM = 16,
   parameter int ADDR_W  = 12
) (
   input logic               clk,
   input logic               reset,
   bnn_conv_engine_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_WLOAD, S_HDR, S_CHK, S_FILL, S_STREAM} state_t;

   localparam logic [5:0] N_MAX = 6'(MAX_DIM);

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]  wmem_addr_q, wmem_addr_d;
   logic [5:0]         cnt_q, cnt_d;
   logic [5:0]         n_q, n_d;
   logic [8:0]         w_q, w_d;
   logic [3:0]         t_q, t_d;
   logic [MAX_DIM-1:0] top_q, mid_q, bot_q;
   logic               shift_en, wr_en, take_hdr;
   logic [MAX_DIM-1:0] row_z;
   logic [8:0]         win;
   logic [5:0]         hdr_n;
   logic               hdr_ok;
   logic               unused_wbits;
`ifdef BNN_CONV_STATUS_EN
   logic [7:0]         img_q, img_d;
   logic               derr_q, derr_d;
   logic               hdr_end;
`endif

   function automatic logic [3:0] popcnt9(input logic [8:0] v);
      logic [3:0] s;
      s = '0;
      for (int i = 0; i < 9; i++) s = s + {3'b000, v[i]};
      return s;
   endfunction

   assign hdr_n        = bus.sram_dut_read_data[5:0];
   assign hdr_ok       = (hdr_n >= 6'd3) && (hdr_n <= N_MAX);
   assign unused_wbits = ^bus.wmem_dut_read_data[15:13];
`ifdef BNN_CONV_STATUS_EN
   assign hdr_end      = &bus.sram_dut_read_data[7:0];
`endif

   // One output bit per window; columns at or beyond N-2 stay zero.
   always_comb begin
      row_z = '0;
      win   = '0;
      for (int c = 0; c < MAX_DIM - 2; c++) begin
         win = {bot_q[c +: 3], mid_q[c +: 3], top_q[c +: 3]};
         if ((c < int'(n_q) - 2) && (popcnt9(~(w_q ^ win)) >= t_q))
            row_z[c] = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      rd_addr_d   = rd_addr_q;
      wr_addr_d   = wr_addr_q;
      wmem_addr_d = wmem_addr_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      w_d         = w_q;
      t_d         = t_q;
      shift_en    = 1'b0;
      wr_en       = 1'b0;
      take_hdr    = 1'b0;
`ifdef BNN_CONV_STATUS_EN
      img_d       = img_q;
      derr_d      = derr_q;
`endif
      unique case (state_q)
         S_IDLE: if (bus.dut_run) begin
            state_d     = S_WLOAD;
            busy_d      = 1'b1;
            wmem_addr_d = ADDR_W'(1);
            rd_addr_d   = '0;
            wr_addr_d   = '0;
`ifdef BNN_CONV_STATUS_EN
            img_d       = '0;
            derr_d      = 1'b0;
`endif
         end
         S_WLOAD: state_d = S_HDR;
         S_HDR: begin
            w_d       = bus.wmem_dut_read_data[8:0];
            t_d       = bus.wmem_dut_read_data[12:9];
            rd_addr_d = rd_addr_q + 1'b1;
            state_d   = S_CHK;
         end
         S_CHK: take_hdr = 1'b1;
         S_FILL: begin
            shift_en  = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            cnt_d     = cnt_q + 6'd1;
            if (cnt_q == 6'd2) begin
               cnt_d   = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            shift_en  = 1'b1;
            wr_en     = 1'b1;
            wr_addr_d = wr_addr_q + 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            cnt_d     = cnt_q + 6'd1;
            // Reads run one word ahead, so the next header arrives with the last row's compute.
            if (cnt_q == n_q - 6'd3) begin
               take_hdr = 1'b1;
`ifdef BNN_CONV_STATUS_EN
               if (img_q != 8'hFF) img_d = img_q + 8'd1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (take_hdr) begin
         if (hdr_ok) begin
            state_d   = S_FILL;
            n_d       = hdr_n;
            cnt_d     = '0;
            rd_addr_d = rd_addr_q + 1'b1;
         end else begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            rd_addr_d   = '0;
            wmem_addr_d = '0;
`ifdef BNN_CONV_STATUS_EN
            derr_d      = derr_q | ~hdr_end;
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         rd_addr_q   <= '0;
         wr_addr_q   <= '0;
         wmem_addr_q <= '0;
         cnt_q       <= '0;
`ifdef BNN_CONV_STATUS_EN
         img_q       <= '0;
         derr_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         rd_addr_q   <= rd_addr_d;
         wr_addr_q   <= wr_addr_d;
         wmem_addr_q <= wmem_addr_d;
         cnt_q       <= cnt_d;
`ifdef BNN_CONV_STATUS_EN
         img_q       <= img_d;
         derr_q      <= derr_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      n_q <= n_d;
      w_q <= w_d;
      t_q <= t_d;
      if (shift_en) begin
         top_q <= mid_q;
         mid_q <= bot_q;
         bot_q <= bus.sram_dut_read_data;
      end
   end

   assign bus.dut_busy               = busy_q;
   assign bus.dut_sram_read_address  = rd_addr_q;
   assign bus.dut_sram_write_address = wr_addr_q;
   assign bus.dut_sram_write_enable  = wr_en;
   assign bus.dut_sram_write_data    = wr_en ? row_z : '0;
   assign bus.dut_wmem_read_address  = wmem_addr_q;
`ifdef BNN_CONV_STATUS_EN
   assign bus.img_count              = img_q;
   assign bus.dim_error              = derr_q;
`endif
endmodule

// File: tb/tb_bnn_conv_engine.sv
// Scoreboard bench for bnn_conv_engine: image stimulus with a window-level reference model.
module tb_bnn_conv_engine;
   localparam int MAX_DIM = 16;
   localparam int ADDR_W  = 12;

   typedef struct packed {
      logic [11:0] a;
      logic [15:0] d;
   } exp_t;

   logic clk;
   logic reset;
   bnn_conv_engine_if #(.MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W)) bus ();

   bnn_conv_engine #(.MAX_DIM(MAX_DIM), .ADDR_W(ADDR_W)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.master)
   );

   logic [15:0] sram_in [4096];
   logic [15:0] wmem [16];
   exp_t        exp_q [$];
   int          n_checks = 0;
   int          n_err    = 0;
   int          wr_seen  = 0;
   int          wp, wexp, img_cnt_exp, sum_cost;
   logic [8:0]  cur_w;
   logic [3:0]  cur_t;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memories: data follows the address by one clock.
   always @(posedge clk) begin
      bus.sram_dut_read_data <= sram_in[bus.dut_sram_read_address];
      bus.wmem_dut_read_data <= wmem[bus.dut_wmem_read_address[3:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.dut_sram_write_enable === 1'b1) begin
            wr_seen++;
            chk("we_while_busy", 32'(bus.dut_busy), 32'd1);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                        bus.dut_sram_write_address, bus.dut_sram_write_data);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", 32'(bus.dut_sram_write_address), 32'(e.a));
               chk("wr_data", 32'(bus.dut_sram_write_data), 32'(e.d));
            end
         end
      end
   end

   task automatic begin_run(input logic [8:0] w, input logic [3:0] t);
      for (int i = 0; i < 4096; i++) sram_in[i] = 16'h00FF;
      for (int i = 0; i < 16; i++) wmem[i] = 16'($urandom);
      wmem[1]     = {3'b000, t, w};
      cur_w       = w;
      cur_t       = t;
      wp          = 0;
      wexp        = 0;
      img_cnt_exp = 0;
      sum_cost    = 0;
   endtask

   task automatic add_word(input logic [15:0] v);
      sram_in[wp] = v;
      wp++;
   endtask

   // kind: 0 all ones, 1 all zeros, 2 checkerboard, 3 random
   task automatic add_image(input int n, input int kind);
      logic [15:0] rows [32];
      logic [15:0] z;
      int          m;
      add_word(16'(n));
      for (int r = 0; r < n; r++) begin
         case (kind)
            0:       rows[r] = 16'hFFFF;
            1:       rows[r] = 16'h0000;
            2:       rows[r] = (r % 2 == 0) ? 16'hAAAA : 16'h5555;
            default: rows[r] = 16'($urandom);
         endcase
         add_word(rows[r]);
      end
      for (int r = 0; r < n - 2; r++) begin
         z = '0;
         for (int c = 0; c < n - 2; c++) begin
            m = 0;
            for (int dr = 0; dr < 3; dr++)
               for (int dc = 0; dc < 3; dc++)
                  if (rows[r+dr][c+dc] == cur_w[3*dr+dc]) m++;
            if (m >= int'(cur_t)) z[c] = 1'b1;
         end
         exp_q.push_back('{a: 12'(wexp), d: z});
         wexp++;
      end
      img_cnt_exp++;
      sum_cost += n + 3;
   endtask

   task automatic start_run();
      @(posedge clk);
      #1 bus.dut_run = 1'b1;
      @(posedge clk);
      #1 bus.dut_run = 1'b0;
      chk("busy_rise", 32'(bus.dut_busy), 32'd1);
      chk("wmem_addr", 32'(bus.dut_wmem_read_address), 32'd1);
      @(posedge clk);
      #1 chk("hdr_addr", 32'(bus.dut_sram_read_address), 32'd0);
   endtask

   task automatic run_and_wait(input bit exp_err);
      int cyc;
      int bound;
      start_run();
      bound = 4 + sum_cost;
      cyc   = 0;
      while (bus.dut_busy && cyc < bound + 20) begin
         bus.dut_run = (cyc == 10);
         @(posedge clk);
         #1 cyc++;
      end
      bus.dut_run = 1'b0;
      chk("busy_fall", 32'(bus.dut_busy), 32'd0);
      chk("run_len_in_bound", 32'(cyc <= bound), 32'd1);
      chk("writes_all_seen", 32'(exp_q.size()), 32'd0);
      chk("rd_addr_idle", 32'(bus.dut_sram_read_address), 32'd0);
      chk("wmem_addr_idle", 32'(bus.dut_wmem_read_address), 32'd0);
`ifdef BNN_CONV_STATUS_EN
      chk("img_count", 32'(bus.img_count), 32'((img_cnt_exp > 255) ? 255 : img_cnt_exp));
      chk("dim_error", 32'(bus.dim_error), 32'(exp_err));
`else
      if (exp_err) chk("err_run_idle", 32'(bus.dut_busy), 32'd0);
`endif
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(bus.dut_busy), 32'd0);
      chk({tag, "_we"}, 32'(bus.dut_sram_write_enable), 32'd0);
      chk({tag, "_wdata"}, 32'(bus.dut_sram_write_data), 32'd0);
      chk({tag, "_waddr"}, 32'(bus.dut_sram_write_address), 32'd0);
      chk({tag, "_raddr"}, 32'(bus.dut_sram_read_address), 32'd0);
      chk({tag, "_wmaddr"}, 32'(bus.dut_wmem_read_address), 32'd0);
`ifdef BNN_CONV_STATUS_EN
      chk({tag, "_img_count"}, 32'(bus.img_count), 32'd0);
      chk({tag, "_dim_error"}, 32'(bus.dim_error), 32'd0);
`endif
   endtask

   initial begin
      int k;
      int ws0;
      reset       = 1'b1;
      bus.dut_run = 1'b0;
      begin_run(9'h000, 4'd0);
      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      reset = 1'b0;

      // 16x16 all ones, w=0x1FF, T=5
      begin_run(9'h1FF, 4'd5);
      add_image(16, 0);
      add_word(16'h00FF);
      run_and_wait(1'b0);

      // 5x5 all zeros, w=0, T=9
      begin_run(9'h000, 4'd9);
      add_image(5, 1);
      add_word(16'h00FF);
      run_and_wait(1'b0);

      // back-to-back checkerboards 10x10 then 3x3
      begin_run(9'h155, 4'd5);
      add_image(10, 2);
      add_image(3, 2);
      add_word(16'h00FF);
      run_and_wait(1'b0);

      // threshold extremes on random 12x12
      begin_run(9'($urandom), 4'd0);
      add_image(12, 3);
      add_word(16'h00FF);
      run_and_wait(1'b0);
      begin_run(9'($urandom), 4'd10);
      add_image(12, 3);
      add_word(16'h00FF);
      run_and_wait(1'b0);

      // illegal header N=2 after a 4x4 image
      begin_run(9'($urandom), 4'($urandom_range(0, 9)));
      add_image(4, 3);
      add_word(16'h0002);
      run_and_wait(1'b1);

      // random multi-image runs, including a MAX_DIM+1 illegal terminator
      for (int run = 0; run < 4; run++) begin
         begin_run(9'($urandom), 4'($urandom_range(0, 11)));
         for (int i = 0; i < 3; i++) add_image(int'($urandom_range(3, MAX_DIM)), 3);
         add_word((run == 3) ? 16'(MAX_DIM + 1) : 16'h00FF);
         run_and_wait(run == 3);
      end

      // reset mid-stream of a 16x16 image, then a clean restart
      begin_run(9'($urandom), 4'($urandom_range(1, 8)));
      add_image(16, 3);
      add_word(16'h00FF);
      ws0 = wr_seen;
      start_run();
      k = 0;
      while (wr_seen < ws0 + 5 && k < 200) begin
         @(posedge clk);
         k++;
      end
      chk("mid_stream_reached", 32'(k < 200), 32'd1);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 exp_q.delete();
      chk_all_zero("midrst");
      ws0 = wr_seen;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("no_writes_after_reset", 32'(wr_seen), 32'(ws0));
      begin_run(9'($urandom), 4'($urandom_range(0, 9)));
      add_image(5, 3);
      add_word(16'h00FF);
      run_and_wait(1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end
endmodule
